// File: rtl/i2c_mem_sequencer.sv
// Arbitrates between the I2C engine and a local host. Each request becomes an
// address lookup followed by up to NBYTES single-byte transfers to the slave memory.
module i2c_mem_sequencer #(
   parameter int ADDRESSLENGTH = 8,
   parameter int NBYTES = 2,
   localparam int NBW = $clog2(NBYTES + 1)
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     IReq,
   input  logic                     IRorW,
   input  logic [ADDRESSLENGTH-1:0] IAddr,
   input  logic [NBW-1:0]           INum,
   input  logic [8*NBYTES-1:0]      IWData,
   input  logic                     HReq,
   input  logic                     HRorW,
   input  logic [ADDRESSLENGTH-1:0] HAddr,
   input  logic [NBW-1:0]           HNum,
   input  logic [8*NBYTES-1:0]      HWData,
   output logic                     IDone,
   output logic                     HDone,
   output logic                     Found,
   output logic [8*NBYTES-1:0]      RData,
   output logic                     Busy,
   output logic                     MemEnable,
   output logic                     MemMode,
   output logic                     MemRorW,
   output logic [ADDRESSLENGTH-1:0] MemAddr,
   output logic [7:0]               MemWData,
   input  logic [7:0]               MemRData,
   input  logic                     MemAddressFound
);

   typedef enum logic [2:0] {
      IDLE, LOOKUP_EN, LOOKUP_CHK, XFER_SETUP, XFER_EN, XFER_CAP, DONE
   } stateT;

   localparam logic [NBW-1:0] MAXNUM = NBW'(NBYTES);

   stateT                    state, nextState;
   logic                     grantHost, lastGrantHost, grantHostNext;
   logic                     rorwQ;
   logic [ADDRESSLENGTH-1:0] addrQ;
   logic [NBW-1:0]           numQ, byteIdx, reqNum, byteIdxInc;
   logic [8*NBYTES-1:0]      wdataQ, rdataQ;
   logic                     foundQ;

   // On a tie the host only wins when the previous grant went to the I2C engine.
   assign grantHostNext = HReq && (!IReq || !lastGrantHost);
   assign reqNum        = grantHostNext ? HNum : INum;
   assign byteIdxInc    = NBW'(byteIdx + 1'b1);

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:       if (IReq || HReq) nextState = LOOKUP_EN;
         LOOKUP_EN:  nextState = LOOKUP_CHK;
         LOOKUP_CHK: nextState = (!MemAddressFound || numQ == '0) ? DONE : XFER_SETUP;
         XFER_SETUP: nextState = XFER_EN;
         XFER_EN:    nextState = XFER_CAP;
         XFER_CAP:   nextState = (byteIdxInc == numQ) ? DONE : XFER_SETUP;
         DONE:       nextState = IDLE;
         default:    nextState = IDLE;
      endcase
   end

   // Request fields are captured once at grant so the requester may change them freely afterwards.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         grantHost     <= 1'b0;
         lastGrantHost <= 1'b1;
         rorwQ         <= 1'b0;
         addrQ         <= '0;
         numQ          <= '0;
         wdataQ        <= '0;
         byteIdx       <= '0;
         foundQ        <= 1'b0;
         rdataQ        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (IReq || HReq) begin
                  grantHost <= grantHostNext;
                  rorwQ     <= grantHostNext ? HRorW : IRorW;
                  addrQ     <= grantHostNext ? HAddr : IAddr;
                  wdataQ    <= grantHostNext ? HWData : IWData;
                  numQ      <= (reqNum > MAXNUM) ? MAXNUM : reqNum;
                  foundQ    <= 1'b0;
                  rdataQ    <= '0;
               end
            end
            LOOKUP_CHK: begin
               foundQ  <= MemAddressFound;
               byteIdx <= '0;
            end
            XFER_CAP: begin
               if (!rorwQ) rdataQ[8*byteIdx +: 8] <= MemRData;
               byteIdx <= byteIdxInc;
            end
            DONE: lastGrantHost <= grantHost;
            default: ;
         endcase
      end
   end

   // Everything is decoded from the state and forced low while Reset is high.
   always_comb begin
      MemEnable = 1'b0;
      MemMode   = 1'b0;
      MemRorW   = 1'b0;
      MemAddr   = '0;
      MemWData  = '0;
      IDone     = 1'b0;
      HDone     = 1'b0;
      Found     = 1'b0;
      RData     = '0;
      Busy      = 1'b0;
      if (!Reset) begin
         Busy  = (state != IDLE);
         Found = foundQ;
         RData = rdataQ;
         if (state != IDLE) MemAddr = addrQ;
         case (state)
            LOOKUP_EN: MemEnable = 1'b1;
            XFER_SETUP, XFER_EN, XFER_CAP: begin
               MemMode   = 1'b1;
               MemRorW   = rorwQ;
               MemWData  = wdataQ[8*byteIdx +: 8];
               MemEnable = (state == XFER_EN);
            end
            DONE: begin
               IDone = !grantHost;
               HDone = grantHost;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_mem_sequencer.sv
// Directed bench for i2c_mem_sequencer with a small slave memory that maps
// address 8'h55 and auto-increments a byte pointer on each transfer.
module tb_i2c_mem_sequencer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        IReq, IRorW, HReq, HRorW;
   logic [7:0]  IAddr, HAddr;
   logic [1:0]  INum, HNum;
   logic [15:0] IWData, HWData;
   logic        IDone, HDone, Found, Busy;
   logic [15:0] RData;
   logic        MemEnable, MemMode, MemRorW;
   logic [7:0]  MemAddr, MemWData;
   logic [7:0]  MemRData;
   logic        MemAddressFound;

   int assertCount = 0;
   int failCount   = 0;
   int backToBack  = 0;
   logic prevEn    = 1'b0;

   logic [7:0] memArr [0:3];
   logic [1:0] memPtr;

   i2c_mem_sequencer #(.ADDRESSLENGTH(8), .NBYTES(2)) dut (
      .Clk(Clk), .Reset(Reset),
      .IReq(IReq), .IRorW(IRorW), .IAddr(IAddr), .INum(INum), .IWData(IWData),
      .HReq(HReq), .HRorW(HRorW), .HAddr(HAddr), .HNum(HNum), .HWData(HWData),
      .IDone(IDone), .HDone(HDone), .Found(Found), .RData(RData), .Busy(Busy),
      .MemEnable(MemEnable), .MemMode(MemMode), .MemRorW(MemRorW),
      .MemAddr(MemAddr), .MemWData(MemWData),
      .MemRData(MemRData), .MemAddressFound(MemAddressFound)
   );

   always #5 Clk = ~Clk;

   // Slave memory: lookup resets the pointer, each transfer pulse moves one byte.
   always @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 4; i++) memArr[i] <= 8'h00;
         memPtr          <= 2'd0;
         MemRData        <= 8'h00;
         MemAddressFound <= 1'b0;
      end else if (MemEnable) begin
         if (!MemMode) begin
            MemAddressFound <= (MemAddr == 8'h55);
            memPtr          <= 2'd0;
         end else begin
            if (MemRorW) memArr[memPtr] <= MemWData;
            else         MemRData <= memArr[memPtr];
            memPtr <= memPtr + 2'd1;
         end
      end
   end

   always @(negedge Clk) begin
      backToBack <= backToBack + ((MemEnable && prevEn) ? 1 : 0);
      prevEn     <= MemEnable;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Issues one request and follows it until its Done pulse or a 40-cycle timeout.
   task automatic applyStimulus(input bit isHost, input logic rorw, input logic [7:0] addr,
                                input logic [1:0] num, input logic [15:0] wdata,
                                output int doneCycle, output logic foundV, output logic [15:0] rdataV,
                                output int lookups, output int xfers, output logic [15:0] wrBytes,
                                output int wrongDone, output logic busy1);
      doneCycle = -1; foundV = 1'bx; rdataV = 'x; lookups = 0; xfers = 0;
      wrBytes = 16'h0000; wrongDone = 0; busy1 = 1'b0;
      @(negedge Clk);
      if (isHost) begin
         HReq = 1'b1; HRorW = rorw; HAddr = addr; HNum = num; HWData = wdata;
      end else begin
         IReq = 1'b1; IRorW = rorw; IAddr = addr; INum = num; IWData = wdata;
      end
      @(posedge Clk);
      for (int c = 1; c <= 40 && doneCycle < 0; c++) begin
         @(negedge Clk);
         if (c == 1) busy1 = Busy;
         if (MemEnable) begin
            if (MemMode) begin
               if (MemRorW && xfers < 2) wrBytes[8*xfers +: 8] = MemWData;
               xfers++;
            end else lookups++;
         end
         if (isHost ? IDone : HDone) wrongDone++;
         if (isHost ? HDone : IDone) begin
            doneCycle = c; foundV = Found; rdataV = RData;
            HReq = 1'b0; IReq = 1'b0;
         end
      end
   endtask

   // Raises both requests together and records which port finishes first and second (9 = none).
   task automatic applyTie(output int first, output int second);
      int order [2];
      int n = 0;
      order[0] = 9; order[1] = 9;
      @(negedge Clk);
      IReq = 1'b1; IRorW = 1'b0; IAddr = 8'h55; INum = 2'd0;
      HReq = 1'b1; HRorW = 1'b0; HAddr = 8'h2F; HNum = 2'd0;
      for (int c = 0; c < 60 && n < 2; c++) begin
         @(negedge Clk);
         if (IDone && n < 2) begin order[n] = 0; n++; IReq = 1'b0; end
         if (HDone && n < 2) begin order[n] = 1; n++; HReq = 1'b0; end
      end
      IReq = 1'b0; HReq = 1'b0;
      first = order[0]; second = order[1];
   endtask

   int dc, lk, xf, wd, first, second, sawDone, enCount;
   logic fv, b1;
   logic [15:0] rd, wb;

   initial begin
      Reset = 1'b1;
      IReq = 0; IRorW = 0; IAddr = 0; INum = 0; IWData = 0;
      HReq = 0; HRorW = 0; HAddr = 0; HNum = 0; HWData = 0;

      // Reset state: every output low while Reset is held.
      repeat (2) begin
         @(negedge Clk);
         checkOutput("resetOutputs", {MemEnable, MemMode, MemRorW, MemAddr, MemWData,
                                      IDone, HDone, Found, RData, Busy}, 64'd0);
      end
      @(negedge Clk); Reset = 1'b0;
      enCount = 0;
      repeat (4) begin
         @(negedge Clk);
         if (MemEnable || Busy) enCount++;
      end
      checkOutput("idleQuiet", enCount, 0);

      // Host 2-byte write to a mapped address.
      applyStimulus(1'b1, 1'b1, 8'h55, 2'd2, 16'hF555, dc, fv, rd, lk, xf, wb, wd, b1);
      checkOutput("hWrDoneCycle", dc, 9);
      checkOutput("hWrFound", fv, 1);
      checkOutput("hWrRData", rd, 16'h0000);
      checkOutput("hWrLookups", lk, 1);
      checkOutput("hWrXfers", xf, 2);
      checkOutput("hWrBytes", wb, 16'hF555);
      checkOutput("hWrNoIDone", wd, 0);
      checkOutput("hWrBusy", b1, 1);

      // I2C read of the bytes just written.
      applyStimulus(1'b0, 1'b0, 8'h55, 2'd2, 16'h0000, dc, fv, rd, lk, xf, wb, wd, b1);
      checkOutput("iRdDoneCycle", dc, 9);
      checkOutput("iRdFound", fv, 1);
      checkOutput("iRdRData", rd, 16'hF555);
      checkOutput("iRdNoHDone", wd, 0);

      // Host read of an unmapped address: lookup only, stale read data cleared.
      applyStimulus(1'b1, 1'b0, 8'h2F, 2'd2, 16'h0000, dc, fv, rd, lk, xf, wb, wd, b1);
      checkOutput("missDoneCycle", dc, 3);
      checkOutput("missFound", fv, 0);
      checkOutput("missRData", rd, 16'h0000);
      checkOutput("missPulses", lk + xf, 1);

      // Oversized count is clamped to two bytes.
      applyStimulus(1'b0, 1'b0, 8'h55, 2'd3, 16'h0000, dc, fv, rd, lk, xf, wb, wd, b1);
      checkOutput("clampDoneCycle", dc, 9);
      checkOutput("clampXfers", xf, 2);
      checkOutput("clampRData", rd, 16'hF555);

      // Zero count on a mapped address: lookup only, Found still reported.
      applyStimulus(1'b0, 1'b0, 8'h55, 2'd0, 16'h0000, dc, fv, rd, lk, xf, wb, wd, b1);
      checkOutput("zeroDoneCycle", dc, 3);
      checkOutput("zeroFound", fv, 1);
      checkOutput("zeroXfers", xf, 0);
      checkOutput("zeroRData", rd, 16'h0000);

      // Reset during the first transfer pulse of a host write.
      @(negedge Clk);
      HReq = 1'b1; HRorW = 1'b1; HAddr = 8'h55; HNum = 2'd2; HWData = 16'hA1B2;
      @(posedge Clk);
      repeat (4) @(negedge Clk);
      checkOutput("xferEnBeforeReset", {MemEnable, MemMode}, 2'b11);
      Reset = 1'b1; HReq = 1'b0;
      @(negedge Clk);
      checkOutput("resetMemEnable", MemEnable, 0);
      checkOutput("resetBusy", Busy, 0);
      sawDone = HDone ? 1 : 0;
      Reset = 1'b0;
      repeat (8) begin
         @(negedge Clk);
         if (HDone || IDone) sawDone++;
      end
      checkOutput("resetNoDone", sawDone, 0);
      checkOutput("resetIdleBusy", Busy, 0);

      // Ties: right after reset the I2C port wins.
      applyTie(first, second);
      checkOutput("tie1First", first, 0);
      checkOutput("tie1Second", second, 1);

      // After a lone I2C grant the host wins the next tie.
      applyStimulus(1'b0, 1'b0, 8'h2F, 2'd0, 16'h0000, dc, fv, rd, lk, xf, wb, wd, b1);
      checkOutput("soloDoneCycle", dc, 3);
      applyTie(first, second);
      checkOutput("tie2First", first, 1);
      checkOutput("tie2Second", second, 0);

      repeat (3) @(negedge Clk);
      checkOutput("noBackToBackEnable", backToBack, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
